// File: rtl/dma_irq_ctrl.sv
// DMA interrupt controller: sticky per-source pending/overflow bits, enable mask,
// registered level IRQ and priority-encoded source ID. Optional coalescing via DMA_IRQ_COALESCE_EN.
module dma_irq_ctrl #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned CNT_W   = 8,
   localparam int unsigned ID_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_SRC-1:0] evt_i,
   input  logic [NUM_SRC-1:0] mask_i,
   input  logic               clr_valid_i,
   input  logic [NUM_SRC-1:0] clr_mask_i,
   input  logic [CNT_W-1:0]   cfg_thresh_i,
   input  logic [CNT_W-1:0]   cfg_timeout_i,
   output logic               irq_o,
   output logic [ID_W-1:0]    irq_id_o,
   output logic [NUM_SRC-1:0] pending_o,
   output logic [NUM_SRC-1:0] overflow_o,
   output logic [1:0]         dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_FIRE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] overflow_q, overflow_d;
   logic               irq_q;
   logic [NUM_SRC-1:0] clr_vec;
   logic [NUM_SRC-1:0] act_vec;
   logic               active;
   logic [ID_W-1:0]    irq_id;

   // A coinciding event always beats the W1C so no event is lost.
   assign clr_vec    = clr_valid_i ? clr_mask_i : '0;
   assign pending_d  = (pending_q & ~clr_vec) | evt_i;
   assign overflow_d = (overflow_q & ~clr_vec) | (evt_i & pending_q);
   assign act_vec    = pending_q & mask_i;
   assign active     = |act_vec;

   always_comb begin
      irq_id = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (act_vec[i]) irq_id = ID_W'(i);
      end
   end

`ifdef DMA_IRQ_COALESCE_EN
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [31:0]      act_cnt;
   logic             wait_done;

   always_comb begin
      act_cnt = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         act_cnt = act_cnt + {31'd0, act_vec[i]};
      end
   end

   assign wait_done = (act_cnt >= {{(32-CNT_W){1'b0}}, cfg_thresh_i}) ||
                      (timer_q == cfg_timeout_i);

   // Timer runs only while staying in WAIT; any exit resets it.
   always_comb begin
      timer_d = '0;
      if (state_q == ST_WAIT && state_d == ST_WAIT) begin
         timer_d = (timer_q == {CNT_W{1'b1}}) ? timer_q : timer_q + 1'b1;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{cfg_thresh_i, cfg_timeout_i};
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
`ifdef DMA_IRQ_COALESCE_EN
            if (active) state_d = ST_WAIT;
`else
            if (active) state_d = ST_FIRE;
`endif
         end
         ST_WAIT: begin
`ifdef DMA_IRQ_COALESCE_EN
            if (!active)        state_d = ST_IDLE;
            else if (wait_done) state_d = ST_FIRE;
`else
            state_d = ST_IDLE;
`endif
         end
         ST_FIRE: begin
            if (!active) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         pending_q  <= '0;
         overflow_q <= '0;
         irq_q      <= 1'b0;
`ifdef DMA_IRQ_COALESCE_EN
         timer_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         irq_q      <= (state_d == ST_FIRE);
`ifdef DMA_IRQ_COALESCE_EN
         timer_q    <= timer_d;
`endif
      end
   end

   assign irq_o       = irq_q;
   assign irq_id_o    = irq_id;
   assign pending_o   = pending_q;
   assign overflow_o  = overflow_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dma_irq_ctrl.sv
// Randomized and directed bench for dma_irq_ctrl against a behavioural model
// of the pending/overflow/IRQ rules (optionally with coalescing).
module tb_dma_irq_ctrl;
  localparam int N  = 4;
  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  logic [N-1:0]  evt_i, mask_i, clr_mask_i;
  logic          clr_valid_i;
  logic [CW-1:0] cfg_thresh_i, cfg_timeout_i;
  logic          irq_o;
  logic [1:0]    irq_id_o;
  logic [N-1:0]  pending_o, overflow_o;
  logic [1:0]    dbg_state_o;

  dma_irq_ctrl #(.NUM_SRC(N), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .evt_i(evt_i), .mask_i(mask_i),
    .clr_valid_i(clr_valid_i), .clr_mask_i(clr_mask_i),
    .cfg_thresh_i(cfg_thresh_i), .cfg_timeout_i(cfg_timeout_i),
    .irq_o(irq_o), .irq_id_o(irq_id_o), .pending_o(pending_o),
    .overflow_o(overflow_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [10:0] exp_q[$];   // {irq, id[1:0], overflow[3:0], pending[3:0]}

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0] m_pend, m_ovf;
  logic         m_irq;
  int           m_wait;   // cycles spent waiting to coalesce, -1 when not waiting

  function automatic logic [1:0] lowest_set(input logic [N-1:0] v);
    logic [1:0] id = 2'd0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) id = 2'(i);
    return id;
  endfunction

  function automatic int count_ones(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) if (v[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_ovf = '0; m_irq = 1'b0; m_wait = -1;
    exp_q.delete();
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic [N-1:0] enabled;
    logic         any_on;
    enabled = m_pend & mask_i;
    any_on  = (enabled != 0);
`ifdef DMA_IRQ_COALESCE_EN
    if (!any_on) begin
      m_irq = 1'b0; m_wait = -1;
    end else if (!m_irq) begin
      if (m_wait < 0) m_wait = 0;
      else if (count_ones(enabled) >= int'(cfg_thresh_i) || m_wait == int'(cfg_timeout_i)) begin
        m_irq = 1'b1; m_wait = -1;
      end else if (m_wait < 255) m_wait++;
    end
`else
    m_irq = any_on;
`endif
    for (int i = 0; i < N; i++) begin
      if (evt_i[i]) begin
        if (m_pend[i]) m_ovf[i] = 1'b1;
        m_pend[i] = 1'b1;
      end else if (clr_valid_i && clr_mask_i[i]) begin
        m_pend[i] = 1'b0;
        m_ovf[i]  = 1'b0;
      end
    end
    exp_q.push_back({m_irq, lowest_set(m_pend & mask_i), m_ovf, m_pend});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [10:0] e;
    model_edge();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("irq",      {31'd0, irq_o},      {31'd0, e[10]});
    check_eq("irq_id",   {30'd0, irq_id_o},   {30'd0, e[9:8]});
    check_eq("overflow", {28'd0, overflow_o}, {28'd0, e[7:4]});
    check_eq("pending",  {28'd0, pending_o},  {28'd0, e[3:0]});
  endtask

  task automatic drive(input logic [N-1:0] evt, input logic cv, input logic [N-1:0] cm);
    evt_i = evt; clr_valid_i = cv; clr_mask_i = cm;
    step();
    evt_i = '0; clr_valid_i = 1'b0; clr_mask_i = '0;
  endtask

  task automatic apply_reset(input string tag);
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_eq({tag, "_irq"},  {31'd0, irq_o},      32'd0);
    check_eq({tag, "_pend"}, {28'd0, pending_o},  32'd0);
    check_eq({tag, "_ovf"},  {28'd0, overflow_o}, 32'd0);
    check_eq({tag, "_id"},   {30'd0, irq_id_o},   32'd0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    rst_ni = 1'b1; evt_i = '0; mask_i = '0; clr_valid_i = 1'b0; clr_mask_i = '0;
    cfg_thresh_i = '0; cfg_timeout_i = '0;
    model_reset();
    #1;
    apply_reset("reset");

`ifndef DMA_IRQ_COALESCE_EN
    mask_i = 4'b1111;
    drive(4'b0100, 1'b0, 4'b0000);
    check_eq("t2_pend", {28'd0, pending_o}, 32'h4);
    check_eq("t2_irq_early", {31'd0, irq_o}, 32'd0);
    drive(4'b0000, 1'b0, 4'b0000);
    check_eq("t2_irq", {31'd0, irq_o}, 32'd1);
    check_eq("t2_id", {30'd0, irq_id_o}, 32'd2);
    drive(4'b0000, 1'b1, 4'b0100);
    drive(4'b0000, 1'b0, 4'b0000);
    check_eq("t2_irq_clr", {31'd0, irq_o}, 32'd0);

    drive(4'b1010, 1'b0, 4'b0000);
    drive(4'b0000, 1'b0, 4'b0000);
    check_eq("t3_id_a", {30'd0, irq_id_o}, 32'd1);
    drive(4'b0000, 1'b1, 4'b0010);
    check_eq("t3_id_b", {30'd0, irq_id_o}, 32'd3);
    check_eq("t3_irq", {31'd0, irq_o}, 32'd1);
    drive(4'b0010, 1'b1, 4'b0010);
    check_eq("t3_set_wins", {31'd0, pending_o[1]}, 32'd1);
    drive(4'b0000, 1'b1, 4'b1111);
    drive(4'b0000, 1'b0, 4'b0000);

    drive(4'b0001, 1'b0, 4'b0000);
    drive(4'b0001, 1'b0, 4'b0000);
    check_eq("t4_ovf", {28'd0, overflow_o}, 32'h1);
    drive(4'b0000, 1'b1, 4'b0001);
    check_eq("t4_clr", {28'd0, pending_o | overflow_o}, 32'd0);
    drive(4'b0000, 1'b0, 4'b0000);

    mask_i = 4'b0000;
    drive(4'b0001, 1'b0, 4'b0000);
    drive(4'b0000, 1'b0, 4'b0000);
    check_eq("t5_masked_irq", {31'd0, irq_o}, 32'd0);
    check_eq("t5_masked_pend", {28'd0, pending_o}, 32'h1);
    mask_i = 4'b0001;
    drive(4'b0000, 1'b0, 4'b0000);
    check_eq("t5_unmask_irq", {31'd0, irq_o}, 32'd1);
    apply_reset("t5_rst");
`else
    mask_i = 4'b1111; cfg_thresh_i = 8'd3; cfg_timeout_i = 8'd10;
    drive(4'b0001, 1'b0, 4'b0000);
    drive(4'b0010, 1'b0, 4'b0000);
    waited = 0;
    while (irq_o !== 1'b1 && waited < 40) begin
      drive(4'b0000, 1'b0, 4'b0000);
      waited++;
    end
    check_eq("t6_timeout_cycles", waited, 32'd11);
    drive(4'b0000, 1'b1, 4'b1111);
    drive(4'b0000, 1'b0, 4'b0000);
    drive(4'b0000, 1'b0, 4'b0000);
    drive(4'b0001, 1'b0, 4'b0000);
    drive(4'b0010, 1'b0, 4'b0000);
    drive(4'b0100, 1'b0, 4'b0000);
    check_eq("t6_thresh_early", {31'd0, irq_o}, 32'd0);
    drive(4'b0000, 1'b0, 4'b0000);
    check_eq("t6_thresh_irq", {31'd0, irq_o}, 32'd1);
    apply_reset("t6_rst");
`endif

    // Randomized phase
    mask_i = 4'b1111;
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] ev, cm;
      logic cv;
      if ($urandom_range(0, 19) == 0) mask_i = 4'($urandom);
`ifdef DMA_IRQ_COALESCE_EN
      if ($urandom_range(0, 39) == 0) begin
        cfg_thresh_i  = 8'($urandom_range(0, 4));
        cfg_timeout_i = 8'($urandom_range(0, 15));
      end
`endif
      ev = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      cv = ($urandom_range(0, 5) == 0);
      cm = 4'($urandom);
      if (c == 300) apply_reset("rand_rst");
      else drive(ev, cv, cm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
